// File: rtl/multicycle_ctrl.sv
// Sequencing controller for a multi-cycle MIPS datapath: Moore FSM driving the
// datapath muxes/enables and stalling on a memory ready handshake with timeout.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic [1:0] pc_src,
    output logic       i_or_d,
    output logic       mem_req,
    output logic       mem_we,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [3:0] state,
    output logic       fault
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_JAL    = 4'd11,
        S_JR     = 4'd12,
        S_ADDIEX = 4'd13,
        S_ADDIWB = 4'd14,
        S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [3:0] TIMEOUT_CNT = 4'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [3:0] wait_cnt_q, wait_cnt_d;
    logic       fault_q, fault_d;
    logic       is_load_q, is_load_d;
    logic       in_wait_state;
    logic       timed_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= 4'd0;
            fault_q    <= 1'b0;
            is_load_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            fault_q    <= fault_d;
            is_load_q  <= is_load_d;
        end
    end

    assign in_wait_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign timed_out     = !mem_ready && (wait_cnt_q == TIMEOUT_CNT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
                      else if (timed_out) state_d = S_HALT;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_JAL:       state_d = S_JAL;
                    OP_ADDI:      state_d = S_ADDIEX;
                    default:      state_d = S_HALT;
                endcase
            end
            S_MEMADR: state_d = is_load_q ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
                      else if (timed_out) state_d = S_HALT;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
                      else if (timed_out) state_d = S_HALT;
            S_EXEC:   state_d = (funct == FN_JR) ? S_JR : S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_FETCH;
        endcase
    end

    // Opcode is only trusted in DECODE, so the lw/sw choice is latched there.
    always_comb begin
        is_load_d = (state_q == S_DECODE) ? (opcode == OP_LW) : is_load_q;
        fault_d   = fault_q || (state_d == S_HALT);
        if (state_d != state_q)
            wait_cnt_d = 4'd0;
        else if (in_wait_state && !mem_ready)
            wait_cnt_d = wait_cnt_q + 4'd1;
        else
            wait_cnt_d = wait_cnt_q;
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        i_or_d        = 1'b0;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 2'd0;
        mem_to_reg    = 2'd0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: alu_src_b = 2'd3;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEMWR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 2'd1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 2'd1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_src        = 2'd1;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = 2'd2;
            end
            S_JAL: begin
                pc_write   = 1'b1;
                pc_src     = 2'd2;
                reg_write  = 1'b1;
                reg_dst    = 2'd2;
                mem_to_reg = 2'd2;
            end
            S_JR: begin
                pc_write = 1'b1;
                pc_src   = 2'd3;
            end
            default: ;
        endcase
    end

    assign state = state_q;
    assign fault = fault_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style sequencing controller for a multi-cycle variant of the MIPS datapath. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the shared ALU's `alu_op`. It also drives every datapath mux and enable, and stalls on a memory ready handshake. It sits between the instruction register and the ALU control decoder. The ALU control decoder turns `alu_op` plus `funct` into the ALU function.

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles spent waiting on `mem_ready` before the access is aborted and `fault` is raised.
- `clk` input 1: single clock; all state updates occur on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `opcode` input 6: IR[31:26], valid from DECODE onward.
- `funct` input 6: IR[5:0]; the only value used here is 6'h08 (jr).
- `mem_ready` input 1: memory has completed the current access this cycle.
- `pc_write` output 1: unconditional PC load.
- `pc_write_cond` output 1: PC load gated by the ALU EQ result (beq).
- `pc_src` output 2: PC source select. 0 = ALU result, 1 = ALUOut (branch target), 2 = jump target, 3 = rs register (jr).
- `i_or_d` output 1: memory address select. 0 = PC, 1 = ALUOut.
- `mem_req` output 1: memory access request.
- `mem_we` output 1: write strobe qualifying `mem_req`.
- `ir_write` output 1: IR load.
- `reg_write` output 1: register file write.
- `reg_dst` output 2: destination register select. 0 = rt, 1 = rd, 2 = $31.
- `mem_to_reg` output 2: writeback data select. 0 = ALUOut, 1 = MDR, 2 = PC.
- `alu_src_a` output 1: ALU operand A select. 0 = PC, 1 = rs.
- `alu_src_b` output 2: ALU operand B select. 0 = rt, 1 = const 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2.
- `alu_op` output 2: to the ALU control decoder. 00 = add, 01 = eq, 10 = funct.
- `state` output 4: current state, for debug and verification.
- `fault` output 1: sticky flag. Set on an illegal opcode or a memory timeout.

## Operation
- State encodings:
  - IDLE = 0, FETCH = 1, DECODE = 2, MEMADR = 3, MEMRD = 4, MEMWB = 5, MEMWR = 6.
  - EXEC = 7, ALUWB = 8, BRANCH = 9, JUMP = 10, JAL = 11, JR = 12, ADDIEX = 13, ADDIWB = 14, HALT = 15.
- State transitions:
  - IDLE→FETCH unconditionally.
  - FETCH holds until `mem_ready`, then goes to DECODE.
  - DECODE dispatches on `opcode`:
    - 0x00 → EXEC.
    - 0x23 or 0x2B → MEMADR.
    - 0x04 → BRANCH.
    - 0x02 → JUMP.
    - 0x03 → JAL.
    - 0x08 → ADDIEX.
    - any other opcode → HALT with `fault` set.
  - MEMADR → MEMRD (lw) or MEMWR (sw).
  - MEMRD holds until `mem_ready`, then → MEMWB.
  - MEMWR holds until `mem_ready`, then → FETCH.
  - EXEC → JR if `funct` = 0x08, otherwise → ALUWB.
  - ADDIEX → ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH, JUMP, JAL and JR all → FETCH.
  - HALT is absorbing; only reset leaves it.
- Output assertions. Any output not listed for a state is 0.
  - FETCH: `mem_req`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=00, `pc_src`=0.
    - `ir_write` and `pc_write` assert only in the cycle where `mem_ready`=1.
  - DECODE: `alu_src_a`=0, `alu_src_b`=3, `alu_op`=00. This precomputes the branch target into ALUOut.
  - MEMADR and ADDIEX: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=00.
  - MEMRD: `mem_req`=1, `i_or_d`=1.
  - MEMWR: `mem_req`=1, `mem_we`=1, `i_or_d`=1.
  - MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1.
  - EXEC: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=10.
  - ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0.
  - ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=01, `pc_write_cond`=1, `pc_src`=1.
  - JUMP: `pc_write`=1, `pc_src`=2.
  - JAL: `pc_write`=1, `pc_src`=2, `reg_write`=1, `reg_dst`=2, `mem_to_reg`=2. This captures PC+4 before the PC update.
  - JR: `pc_write`=1, `pc_src`=3.
- Memory timeout:
  - A 4-bit wait counter clears on entry to FETCH, MEMRD or MEMWR.
  - It increments on each wait cycle with `mem_ready`=0.
  - When the counter equals `MEM_TIMEOUT` with `mem_ready` still 0, the next state is HALT with `fault`=1.

## Timing
- Reset: `rst_n` low forces state = IDLE immediately.
  - All outputs read 0 during reset, including `state` and `fault`.
  - This holds when reset asserts mid-instruction; any in-flight `mem_req` drops in the same cycle, without waiting for a clock edge.
- All outputs are pure decodes of the registered state. The exceptions are the `mem_ready`-qualified `ir_write` and `pc_write` in FETCH, which are combinational on `mem_ready`.
- Latency per instruction, from FETCH entry to the next FETCH entry, with `mem_ready` asserted on the first request cycle:
  - lw 5 cycles.
  - sw 4 cycles.
  - R-type, addi and jr 4 cycles.
  - beq, j and jal 3 cycles.
  - Each cycle of `mem_ready`=0 adds one cycle.
- `mem_ready` is sampled only in FETCH, MEMRD and MEMWR; it is ignored in every other state.
- `mem_ready`=1 in the exact cycle the counter reaches `MEM_TIMEOUT`: the access completes normally and no fault is raised.
- `opcode` and `funct` are sampled only in DECODE and EXEC.

## Test plan
- Reset then release, `mem_ready` tied 1, `opcode`=0x00, `funct`=0x20 → `state` sequence 0,1,2,7,8,1. `alu_op`=10 in EXEC; `reg_write`=1 and `reg_dst`=1 in ALUWB.
- `opcode`=0x23 with `mem_ready` low for 3 cycles in MEMRD → MEMRD lasts 4 cycles and `mem_req` stays 1 throughout; MEMWB then asserts `mem_to_reg`=1; total lw latency is 8 cycles.
- `opcode`=0x04 → BRANCH shows `alu_op`=01, `pc_write_cond`=1, `pc_src`=1, and returns to FETCH 3 cycles after FETCH entry.
- `opcode`=0x00, `funct`=0x08 → JR with `pc_write`=1 and `pc_src`=3, and no `reg_write` at any point in the instruction.
- `opcode`=0x3F → HALT with `fault`=1, holding for 20 cycles with all other outputs 0.
- `mem_ready` held at 0 in FETCH → HALT after 16 cycles with `fault`=1. Asserting `rst_n` low mid-MEMWR → `mem_req` and `mem_we` read 0 immediately and `state` = 0.
